// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and branch-resolution controller: load-use and branch-operand
// stalls, ID comparator forwarding selects, taken-branch redirect/flush and perf counters.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_zero,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pc_src,
  output logic [1:0]       fwd_a_id,
  output logic [1:0]       fwd_b_id,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, wb_rs_hit, wb_rt_hit;
  logic ex_hit, mem_hit;
  logic [1:0] need;
  logic stall;

  // $0 is hard-wired, so a write to it never creates a dependency
  assign ex_rs_hit  = ex_reg_write  && (ex_rd  != 5'd0) && (ex_rd  == id_rs) && id_uses_rs;
  assign ex_rt_hit  = ex_reg_write  && (ex_rd  != 5'd0) && (ex_rd  == id_rt) && id_uses_rt;
  assign mem_rs_hit = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rs) && id_uses_rs;
  assign mem_rt_hit = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rt) && id_uses_rt;
  assign wb_rs_hit  = wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == id_rs) && id_uses_rs;
  assign wb_rt_hit  = wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == id_rt) && id_uses_rt;
  assign ex_hit     = ex_rs_hit || ex_rt_hit;
  assign mem_hit    = mem_rs_hit || mem_rt_hit;

  // Load in EX feeding a branch is the only case needing two bubbles
  always_comb begin
    need = 2'd0;
    if (ex_mem_read && ex_hit) begin
      need = id_branch ? 2'd2 : 2'd1;
    end else if (id_branch && ex_hit) begin
      need = 2'd1;
    end else if (id_branch && mem_mem_read && mem_hit) begin
      need = 2'd1;
    end
  end

  // A load in MEM has no data yet, so it never forwards to the comparator
  always_comb begin
    fwd_a_id = 2'b00;
    fwd_b_id = 2'b00;
    if (!rst) begin
      if (mem_rs_hit && !mem_mem_read) fwd_a_id = 2'b01;
      else if (wb_rs_hit)              fwd_a_id = 2'b10;
      if (mem_rt_hit && !mem_mem_read) fwd_b_id = 2'b01;
      else if (wb_rt_hit)              fwd_b_id = 2'b10;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b1;
    ifid_flush  = 1'b0;
    pc_src      = 1'b0;
    stall       = 1'b0;
    if (rst) begin
      state_d    = RUN;
      ifid_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (need != 2'd0) begin
            stall = 1'b1;
            if (need == 2'd2) state_d = STALL;
          end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
            if (id_branch && id_zero) begin
              pc_src     = 1'b1;
              ifid_flush = 1'b1;
            end
          end
        end
        STALL: begin
          stall   = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (rst) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall && !(&stall_count_q))      stall_count_d = stall_count_q + CNT_ONE;
      if (ifid_flush && !(&flush_count_q)) flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed pipeline scenarios plus randomized cycles
// checked against a stall-budget reference model; a CNT_W=2 copy checks saturation.
module tb_id_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_branch, id_zero;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write;

  logic        pc_write, ifid_write, idex_bubble, ifid_flush, pc_src;
  logic [1:0]  fwd_a_id, fwd_b_id;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush, s_pc_src;
  logic [1:0]  s_fwd_a_id, s_fwd_b_id;
  logic [1:0]  s_stall_count, s_flush_count;

  logic [4:0] ctl;
  logic [8:0] obs;
  assign ctl = {pc_write, ifid_write, idex_bubble, ifid_flush, pc_src};
  assign obs = {ctl, fwd_a_id, fwd_b_id};

  id_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_zero(id_zero),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .pc_src(pc_src),
    .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  id_hazard_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_zero(id_zero),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_bubble(s_idex_bubble),
    .ifid_flush(s_ifid_flush), .pc_src(s_pc_src),
    .fwd_a_id(s_fwd_a_id), .fwd_b_id(s_fwd_b_id),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding bubbles owed plus plain event totals
  int m_rem = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  function automatic logic hit(logic we, logic [4:0] rd, logic [4:0] r, logic uses);
    return we && (rd != 5'd0) && (rd == r) && uses;
  endfunction

  function automatic int need_now();
    int  n;
    logic exh, memh;
    n    = 0;
    exh  = hit(ex_reg_write, ex_rd, id_rs, id_uses_rs) || hit(ex_reg_write, ex_rd, id_rt, id_uses_rt);
    memh = hit(mem_reg_write, mem_rd, id_rs, id_uses_rs) || hit(mem_reg_write, mem_rd, id_rt, id_uses_rt);
    if (ex_mem_read && exh) n = id_branch ? 2 : 1;
    if (id_branch && exh && !ex_mem_read && n < 1) n = 1;
    if (id_branch && mem_mem_read && memh && n < 1) n = 1;
    return n;
  endfunction

  function automatic logic [1:0] fwd_sel(logic [4:0] r, logic uses);
    if (hit(mem_reg_write, mem_rd, r, uses) && !mem_mem_read) return 2'b01;
    if (hit(wb_reg_write, wb_rd, r, uses)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [8:0] model_outs();
    logic [1:0] fa, fb;
    logic tk;
    if (rst) return 9'b00110_00_00;
    fa = fwd_sel(id_rs, id_uses_rs);
    fb = fwd_sel(id_rt, id_uses_rt);
    if (m_rem > 0 || need_now() > 0) return {5'b00100, fa, fb};
    tk = id_branch && id_zero;
    return {1'b1, 1'b1, 1'b0, tk, tk, fa, fb};
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic advance();
    int n;
    if (rst) begin
      m_rem = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1; m_stalls = m_stalls + 1;
    end else begin
      n = need_now();
      if (n > 0) begin
        m_rem = n - 1; m_stalls = m_stalls + 1;
      end else if (id_branch && id_zero) begin
        m_flushes = m_flushes + 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_branch = 1'b0; id_zero = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    wb_rd = 5'd0; wb_reg_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    id_rs = 5'd2; id_uses_rs = 1'b1; ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    wb_rd = 5'd2; wb_reg_write = 1'b1;
    advance();
    settle();
    $display("txn reset: ctl=%b fwd_a=%b stall=%0d flush=%0d", ctl, fwd_a_id, stall_count, flush_count);
    n_checks++; if (ctl !== 5'b00110) begin n_fail++; $display("FAIL reset_ctl: got %b want 00110", ctl); end
    n_checks++; if (fwd_a_id !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a_id); end
    n_checks++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_count, flush_count); end
    rst = 1'b0;
    clear_inputs();
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    id_rs = 5'd2; id_uses_rs = 1'b1; ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    settle();
    $display("txn load_use c1: ctl=%b", ctl);
    n_checks++; if (ctl !== 5'b00100) begin n_fail++; $display("FAIL load_use_stall: got %b want 00100", ctl); end
    advance();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd2; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
    settle();
    $display("txn load_use c2: ctl=%b stall=%0d", ctl, stall_count);
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL load_use_release: got %b want 11000", ctl); end
    n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL load_use_count: got %0d want 1", stall_count); end
    advance();
  endtask

  task automatic test_load_branch();
    do_reset();
    id_branch = 1'b1; id_rs = 5'd2; id_uses_rs = 1'b1;
    ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    settle();
    $display("txn load_branch c1: ctl=%b", ctl);
    n_checks++; if (ctl !== 5'b00100) begin n_fail++; $display("FAIL load_branch_c1: got %b want 00100", ctl); end
    advance();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd2; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
    settle();
    $display("txn load_branch c2: ctl=%b", ctl);
    n_checks++; if (ctl !== 5'b00100) begin n_fail++; $display("FAIL load_branch_c2: got %b want 00100", ctl); end
    advance();
    mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    wb_rd = 5'd2; wb_reg_write = 1'b1;
    settle();
    $display("txn load_branch c3: ctl=%b fwd_a=%b stall=%0d", ctl, fwd_a_id, stall_count);
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL load_branch_c3: got %b want 11000", ctl); end
    n_checks++; if (fwd_a_id !== 2'b10) begin n_fail++; $display("FAIL load_branch_fwd: got %b want 10", fwd_a_id); end
    n_checks++; if (stall_count !== 16'd2) begin n_fail++; $display("FAIL load_branch_count: got %0d want 2", stall_count); end
    advance();
  endtask

  task automatic test_alu_branch();
    do_reset();
    id_branch = 1'b1; id_rt = 5'd3; id_uses_rt = 1'b1;
    ex_rd = 5'd3; ex_reg_write = 1'b1;
    settle();
    $display("txn alu_branch c1: ctl=%b", ctl);
    n_checks++; if (ctl !== 5'b00100) begin n_fail++; $display("FAIL alu_branch_stall: got %b want 00100", ctl); end
    advance();
    ex_reg_write = 1'b0;
    mem_rd = 5'd3; mem_reg_write = 1'b1;
    settle();
    $display("txn alu_branch c2: ctl=%b fwd_b=%b", ctl, fwd_b_id);
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL alu_branch_release: got %b want 11000", ctl); end
    n_checks++; if (fwd_b_id !== 2'b01) begin n_fail++; $display("FAIL alu_branch_fwd_b: got %b want 01", fwd_b_id); end
    advance();
  endtask

  task automatic test_taken_branch();
    do_reset();
    id_branch = 1'b1; id_zero = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    settle();
    $display("txn taken c1: ctl=%b", ctl);
    n_checks++; if (ctl !== 5'b11011) begin n_fail++; $display("FAIL taken_redirect: got %b want 11011", ctl); end
    advance();
    id_zero = 1'b0;
    settle();
    $display("txn taken c2: ctl=%b flush=%0d", ctl, flush_count);
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL not_taken: got %b want 11000", ctl); end
    n_checks++; if (flush_count !== 16'd1) begin n_fail++; $display("FAIL taken_count: got %0d want 1", flush_count); end
    advance();
  endtask

  task automatic test_zero_priority();
    do_reset();
    id_rs = 5'd0; id_uses_rs = 1'b1; ex_rd = 5'd0; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    settle();
    $display("txn reg0: ctl=%b", ctl);
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL reg0_no_stall: got %b want 11000", ctl); end
    advance();
    clear_inputs();
    id_rs = 5'd5; id_uses_rs = 1'b1;
    mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    settle();
    $display("txn priority: fwd_a=%b", fwd_a_id);
    n_checks++; if (fwd_a_id !== 2'b01) begin n_fail++; $display("FAIL mem_priority: got %b want 01", fwd_a_id); end
    advance();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    id_branch = 1'b1; id_rs = 5'd2; id_uses_rs = 1'b1;
    ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    advance();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd2; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
    wb_rd = 5'd2; wb_reg_write = 1'b1;
    settle();
    n_checks++; if (ctl !== 5'b00100) begin n_fail++; $display("FAIL midstall_in_stall: got %b want 00100", ctl); end
    rst = 1'b1;
    settle();
    $display("txn midstall rst: ctl=%b fwd_a=%b", ctl, fwd_a_id);
    n_checks++; if (obs !== 9'b00110_00_00) begin n_fail++; $display("FAIL midstall_reset_outs: got %b want 001100000", obs); end
    advance();
    rst = 1'b0;
    clear_inputs();
    settle();
    $display("txn midstall after: ctl=%b stall=%0d flush=%0d", ctl, stall_count, flush_count);
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL midstall_run: got %b want 11000", ctl); end
    n_checks++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      n_fail++; $display("FAIL midstall_counters: got %0d/%0d want 0/0", stall_count, flush_count); end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    id_rs = 5'd4; id_uses_rs = 1'b1; ex_rd = 5'd4; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    repeat (5) advance();
    clear_inputs();
    settle();
    $display("txn saturation: small=%0d wide=%0d", s_stall_count, stall_count);
    n_checks++; if (s_stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_small: got %0d want 3", s_stall_count); end
    n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL sat_wide: got %0d want 5", stall_count); end
    advance();
  endtask

  task automatic test_random();
    logic [8:0] exp;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_branch = ($urandom_range(0, 2) == 0); id_zero = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3)); ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom); mem_mem_read = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom);
      settle();
      exp = model_outs();
      $display("txn rand %0d: rst=%b outs=%b exp=%b stall=%0d flush=%0d", i, rst, obs, exp, stall_count, flush_count);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rand_outs %0d: got %b want %b", i, obs, exp); end
      n_checks++; if (stall_count !== 16'(m_stalls) || flush_count !== 16'(m_flushes)) begin
        n_fail++; $display("FAIL rand_counters %0d: got %0d/%0d want %0d/%0d", i, stall_count, flush_count, m_stalls, m_flushes); end
      n_checks++; if (s_stall_count !== 2'(sat(m_stalls, 3)) || s_flush_count !== 2'(sat(m_flushes, 3))) begin
        n_fail++; $display("FAIL rand_small_counters %0d: got %0d/%0d want %0d/%0d", i, s_stall_count, s_flush_count,
                          sat(m_stalls, 3), sat(m_flushes, 3)); end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_taken_branch();
    test_zero_priority();
    test_reset_mid_stall();
    test_saturation();
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Hazard and branch-resolution controller for the decode (ID) stage of the 5-stage MIPS pipeline.
- Sequences the ID-stage register-file read, the equality comparator and the branch adder result.
- Detects load-use hazards and branch-operand hazards, then stalls PC and IF/ID and injects ID/EX bubbles.
- Selects forwarding sources for the ID comparator, and redirects and flushes fetch on a taken branch. Keeps saturating stall and flush counters.

Parameters:
CNT_W, 16, width of the stall_count and flush_count performance counters.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_rs  in  5  instruction[25:21] of the instruction in ID
id_rt  in  5  instruction[20:16] of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is beq
id_zero  in  1  ID comparator equal result, taken after forwarding
ex_rd  in  5  destination register in EX
ex_reg_write  in  1  EX instruction writes a register
ex_mem_read  in  1  EX instruction is a load
mem_rd  in  5  destination register in MEM
mem_reg_write  in  1  MEM instruction writes a register
mem_mem_read  in  1  MEM instruction is a load
wb_rd  in  5  destination register in WB
wb_reg_write  in  1  WB instruction writes a register
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register load enable
idex_bubble  out  1  zero the control fields of the ID/EX register
ifid_flush  out  1  clear the IF/ID register to a nop
pc_src  out  1  1 selects the branch adder target for the next PC
fwd_a_id  out  2  comparator operand A source: 00 regfile, 01 MEM ALU result, 10 WB data
fwd_b_id  out  2  same encoding as fwd_a_id, for operand B
stall_count  out  CNT_W  number of stall cycles, saturating
flush_count  out  CNT_W  number of taken-branch flushes, saturating

Behaviour:
- Match definitions. A stage X "matches rs" when X_reg_write=1, X_rd!=0, X_rd==id_rs and id_uses_rs=1. "Matches rt" is the same with id_rt and id_uses_rt. Register $0 never causes a hazard or a forward.
- Hazard classes, evaluated in state RUN only:
  - H_LD_EX: ex_mem_read and EX matches rs or rt. Need 2 if id_branch, else 1.
  - H_ALU_EX: id_branch, EX matches rs or rt, and not ex_mem_read. Need 1.
  - H_LD_MEM: id_branch, mem_mem_read and MEM matches rs or rt. Need 1.
  - The final need is the maximum over all classes that fire.
- Stall outputs: pc_write=0, ifid_write=0, idex_bubble=1, pc_src=0, ifid_flush=0.
- FSM state RUN:
  - If need>0, drive the stall outputs this cycle (combinational).
  - If need=2, go to STALL; otherwise stay in RUN and re-evaluate next cycle.
  - If need=0, drive pc_write=1, ifid_write=1 and idex_bubble=0.
  - If need=0, id_branch=1 and id_zero=1: drive pc_src=1 and ifid_flush=1 in the same cycle.
- FSM state STALL: drive the stall outputs unconditionally, with no hazard evaluation. Go to RUN next cycle.
- A stall always suppresses branch resolution. pc_src and ifid_flush are never asserted in a stall cycle.
- Forwarding, combinational in all states, operand A (B is the same with rt/fwd_b_id):
  - 01 if MEM matches rs and mem_mem_read=0.
  - Else 10 if WB matches rs.
  - Else 00.
  - MEM has priority over WB.
- Counters:
  - stall_count increments on each clock where the stall outputs are driven and rst=0.
  - flush_count increments on each clock where ifid_flush=1 and rst=0.
  - Both saturate at all-ones and never wrap.
- Reset:
  - While rst=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1, pc_src=0, fwd_a_id=fwd_b_id=00.
  - At the edge with rst=1: state goes to RUN and both counters go to 0.
  - Reset asserted during STALL aborts the stall. The first cycle after reset is in RUN.
- Simultaneous events: if both EX and MEM match the same register, EX-stage hazard rules apply and the forward selects MEM. A load in MEM never forwards from MEM; it either stalls (branch) or is handled by the EX forwarding unit (non-branch).

Test Plan:
- Load-use: lw $2 in EX (ex_mem_read=1, ex_rd=2), add in ID reading rs=2 -> exactly 1 cycle pc_write=0, idex_bubble=1; stall_count=1.
- Load then beq: ex_rd=2 load, id_branch=1, id_rs=2 -> 2 stall cycles (RUN then STALL), then RUN with fwd_a_id=10 when wb_rd=2; stall_count=2.
- ALU then beq: ex_rd=3, ex_mem_read=0, beq rt=3 -> 1 stall; next cycle mem_rd=3 gives fwd_b_id=01 and no stall.
- Taken branch: no hazard, id_branch=1, id_zero=1 -> pc_src=1 and ifid_flush=1 for 1 cycle; flush_count=1. The same case with id_zero=0 -> both stay 0.
- $0 and priority: ex_rd=0 load with id_rs=0 -> no stall. mem_rd=wb_rd=5 with id_rs=5 -> fwd_a_id=01.
- Reset mid-STALL: assert rst during STALL -> outputs take reset values; after release, state RUN and counters 0. Force CNT_W=2 with 5 stalls -> stall_count holds at 3.
